// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: byte handshake between an upstream producer and the UART serialiser
interface uart_tx_core_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART frame serialiser stepping one bit per timer tick
module uart_tx_core #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic               clk,
  input  logic               async_nreset,
  uart_tx_core_if.slave      bus,
  input  logic               tick,
  output logic               timer_enable,
  output logic               timer_clear,
  output logic               tx,
  output logic               busy,
  output logic               tx_done
);
  localparam int CW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               r_state, w_state;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic [CW-1:0]        r_bit_cnt, w_bit_cnt, r_stop_cnt, w_stop_cnt;
  logic                 r_par, w_par, r_tx, w_tx, r_done, w_done, w_accept;
  assign bus.tx_ready = r_state == IDLE;
  assign w_accept     = bus.tx_valid && bus.tx_ready;
  assign timer_enable = r_state != IDLE;
  assign timer_clear  = r_state == IDLE;
  assign busy         = r_state != IDLE;
  assign tx           = r_tx;
  assign tx_done      = r_done;
  always_ff @(posedge clk or negedge async_nreset)
    if (!async_nreset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_bit_cnt  <= w_bit_cnt;
      r_stop_cnt <= w_stop_cnt;
      r_par      <= w_par;
      r_tx       <= w_tx;
      r_done     <= w_done;
    end
  // tx is computed one state ahead so the line changes on the same edge as the state
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    w_par      = r_par;
    w_tx       = r_tx;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx = !w_accept;
        if (w_accept) begin
          w_state    = START;
          w_shift    = bus.tx_data;
          w_par      = ^bus.tx_data ^ 1'(PARITY_ODD);
          w_bit_cnt  = '0;
          w_stop_cnt = '0;
        end
      end
      START: if (tick) begin
        w_state = DATA;
        w_tx    = r_shift[0];
      end
      DATA: if (tick) begin
        w_shift   = r_shift >> 1;
        w_bit_cnt = r_bit_cnt + CW'(1);
        if (r_bit_cnt == CW'(DATA_BITS - 1)) begin
          w_state = PARITY_EN != 0 ? PARITY : STOP;
          w_tx    = PARITY_EN != 0 ? r_par : 1'b1;
        end else w_tx = r_shift[1];
      end
      PARITY: if (tick) begin
        w_state = STOP;
        w_tx    = 1'b1;
      end
      STOP: if (tick) begin
        w_stop_cnt = r_stop_cnt + CW'(1);
        if (r_stop_cnt == CW'(STOP_BITS - 1)) begin
          w_state = IDLE;
          w_done  = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed checks of 8N1, 8E1, 8O1 and 8N2 serialisers driven by a 4-clk bit timer
module tb_uart_tx_core;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] v = '0, tick_f = '0;
  logic [3:0] rdy, tick, ten, tclr, txl, bsy, dn;
  logic [7:0] d[4] = '{default: 8'h00};
  logic [1:0] tc[4] = '{default: 2'd0};
  int checks = 0, errors = 0;
  logic [127:0] cap_t, e;
  int cap_done, cap_rdy, cap_busy, cap_dn;

  uart_tx_core_if #(.DATA_BITS(8)) b0(), b1(), b2(), b3();
  assign b0.tx_data = d[0]; assign b0.tx_valid = v[0]; assign rdy[0] = b0.tx_ready;
  assign b1.tx_data = d[1]; assign b1.tx_valid = v[1]; assign rdy[1] = b1.tx_ready;
  assign b2.tx_data = d[2]; assign b2.tx_valid = v[2]; assign rdy[2] = b2.tx_ready;
  assign b3.tx_data = d[3]; assign b3.tx_valid = v[3]; assign rdy[3] = b3.tx_ready;

  uart_tx_core u0 (.clk(clk), .async_nreset(nrst), .bus(b0), .tick(tick[0]), .timer_enable(ten[0]),
    .timer_clear(tclr[0]), .tx(txl[0]), .busy(bsy[0]), .tx_done(dn[0]));
  uart_tx_core #(.PARITY_EN(1)) u1 (.clk(clk), .async_nreset(nrst), .bus(b1), .tick(tick[1]),
    .timer_enable(ten[1]), .timer_clear(tclr[1]), .tx(txl[1]), .busy(bsy[1]), .tx_done(dn[1]));
  uart_tx_core #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .async_nreset(nrst), .bus(b2), .tick(tick[2]),
    .timer_enable(ten[2]), .timer_clear(tclr[2]), .tx(txl[2]), .busy(bsy[2]), .tx_done(dn[2]));
  uart_tx_core #(.STOP_BITS(2)) u3 (.clk(clk), .async_nreset(nrst), .bus(b3), .tick(tick[3]),
    .timer_enable(ten[3]), .timer_clear(tclr[3]), .tx(txl[3]), .busy(bsy[3]), .tx_done(dn[3]));

  // bit timer with terminal count 3; tick_f lets a test inject extra ticks
  always @(posedge clk)
    for (int k = 0; k < 4; k++) tc[k] <= tclr[k] ? 2'd0 : ten[k] ? tc[k] + 2'd1 : tc[k];
  always_comb
    for (int k = 0; k < 4; k++) tick[k] = (ten[k] && tc[k] == 2'd3) | tick_f[k];

  function automatic logic [127:0] expand(input logic [15:0] f, input int nb);
    logic [127:0] r;
    for (int c = 0; c < 128; c++) r[c] = (c < 4 * nb) ? f[c / 4] : 1'b1;
    return r;
  endfunction

  task automatic start(input int k, input logic [7:0] data, input bit hold);
    int n = 0;
    @(negedge clk);
    d[k] = data;
    v[k] = 1'b1;
    while (!rdy[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy[k] !== 1'b1) begin
      errors++;
      $display("FAIL start_timeout k=%0d ready=%b required 1", k, rdy[k]);
    end
    @(negedge clk);
    if (!hold) v[k] = 1'b0;
  endtask

  task automatic capture(input int k, input int n, input int pv);
    cap_t = '1; cap_done = -1; cap_rdy = 0; cap_busy = 0; cap_dn = 0;
    for (int c = 0; c < n; c++) begin
      cap_t[c] = txl[k];
      if (dn[k] && cap_done < 0) cap_done = c;
      cap_dn += int'(dn[k]);
      cap_rdy += int'(rdy[k]);
      cap_busy += int'(bsy[k]);
      if (pv >= 0 && c == pv) begin d[k] = 8'hFF; v[k] = 1'b1; end
      if (pv >= 0 && c == pv + 2) v[k] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 6;
    if (txl !== 4'hF) begin errors++; $display("FAIL rst_tx got %b want 1111", txl); end
    if (rdy !== 4'hF) begin errors++; $display("FAIL rst_ready got %b want 1111", rdy); end
    if (bsy !== 4'h0) begin errors++; $display("FAIL rst_busy got %b want 0000", bsy); end
    if (dn !== 4'h0) begin errors++; $display("FAIL rst_done got %b want 0000", dn); end
    if (ten !== 4'h0) begin errors++; $display("FAIL rst_ten got %b want 0000", ten); end
    if (tclr !== 4'hF) begin errors++; $display("FAIL rst_tclr got %b want 1111", tclr); end
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 2;
    if (txl !== 4'hF) begin errors++; $display("FAIL idle_tx got %b want 1111", txl); end
    if (rdy !== 4'hF) begin errors++; $display("FAIL idle_ready got %b want 1111", rdy); end
  endtask

  task automatic test_8n1;
    start(0, 8'hA5, 1'b0);
    capture(0, 41, -1);
    e = expand({1'b1, 8'hA5, 1'b0}, 10);
    checks += 7;
    if (cap_t !== e) begin errors++; $display("FAIL 8n1_wave got %h want %h", cap_t, e); end
    if (cap_done != 40) begin errors++; $display("FAIL 8n1_done_at got %0d want 40", cap_done); end
    if (cap_rdy != 1) begin errors++; $display("FAIL 8n1_ready_cycles got %0d want 1", cap_rdy); end
    if (cap_busy != 40) begin errors++; $display("FAIL 8n1_busy_cycles got %0d want 40", cap_busy); end
    if (cap_dn != 1) begin errors++; $display("FAIL 8n1_done_pulses got %0d want 1", cap_dn); end
    if (dn[0] !== 1'b0) begin errors++; $display("FAIL 8n1_done_after got %b want 0", dn[0]); end
    if (txl[0] !== 1'b1) begin errors++; $display("FAIL 8n1_tx_after got %b want 1", txl[0]); end
  endtask

  task automatic test_parity;
    for (int k = 1; k <= 2; k++) begin
      start(k, 8'h07, 1'b0);
      capture(k, 45, -1);
      e = expand({1'b1, (k == 1) ? 1'b1 : 1'b0, 8'h07, 1'b0}, 11);
      checks += 2;
      if (cap_t !== e) begin errors++; $display("FAIL parity_wave k=%0d got %h want %h", k, cap_t, e); end
      if (cap_done != 44) begin errors++; $display("FAIL parity_done_at k=%0d got %0d want 44", k, cap_done); end
    end
  endtask

  task automatic test_stop2;
    start(3, 8'h00, 1'b0);
    capture(3, 45, -1);
    e = expand({2'b11, 8'h00, 1'b0}, 11);
    checks += 3;
    if (cap_t !== e) begin errors++; $display("FAIL stop2_wave got %h want %h", cap_t, e); end
    if (cap_done != 44) begin errors++; $display("FAIL stop2_done_at got %0d want 44", cap_done); end
    if (cap_busy != 44) begin errors++; $display("FAIL stop2_busy_cycles got %0d want 44", cap_busy); end
  endtask

  task automatic test_back_to_back;
    start(0, 8'h55, 1'b1);
    d[0] = 8'h0F;
    capture(0, 41, -1);
    v[0] = 1'b0;
    d[0] = 8'hFF;
    e = expand({1'b1, 8'h55, 1'b0}, 10);
    checks += 3;
    if (cap_t !== e) begin errors++; $display("FAIL b2b_wave1 got %h want %h", cap_t, e); end
    if (cap_done != 40) begin errors++; $display("FAIL b2b_done1_at got %0d want 40", cap_done); end
    if (cap_rdy != 1) begin errors++; $display("FAIL b2b_ready1_cycles got %0d want 1", cap_rdy); end
    capture(0, 42, -1);
    e = expand({1'b1, 8'h0F, 1'b0}, 10);
    checks += 3;
    if (cap_t !== e) begin errors++; $display("FAIL b2b_wave2 got %h want %h", cap_t, e); end
    if (cap_done != 40) begin errors++; $display("FAIL b2b_done2_at got %0d want 40", cap_done); end
    if (cap_busy != 40) begin errors++; $display("FAIL b2b_busy2_cycles got %0d want 40", cap_busy); end
  endtask

  task automatic test_busy_ignore;
    start(0, 8'h12, 1'b0);
    capture(0, 44, 10);
    e = expand({1'b1, 8'h12, 1'b0}, 10);
    checks += 3;
    if (cap_t !== e) begin errors++; $display("FAIL ignore_wave got %h want %h", cap_t, e); end
    if (cap_done != 40) begin errors++; $display("FAIL ignore_done_at got %0d want 40", cap_done); end
    if (cap_busy != 40) begin errors++; $display("FAIL ignore_busy_cycles got %0d want 40", cap_busy); end
  endtask

  task automatic test_idle_tick;
    tick_f[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) begin
        errors++;
        $display("FAIL idle_tick cycle %0d tx=%b busy=%b want tx=1 busy=0", i, txl[0], bsy[0]);
      end
    end
    @(negedge clk);
    d[0] = 8'h81;
    v[0] = 1'b1;
    @(posedge clk);
    #1 tick_f[0] = 1'b0;
    @(negedge clk);
    v[0] = 1'b0;
    capture(0, 41, -1);
    e = expand({1'b1, 8'h81, 1'b0}, 10);
    checks += 2;
    if (cap_t !== e) begin errors++; $display("FAIL accept_tick_wave got %h want %h", cap_t, e); end
    if (cap_done != 40) begin errors++; $display("FAIL accept_tick_done_at got %0d want 40", cap_done); end
  endtask

  task automatic test_reset_mid;
    start(0, 8'h3C, 1'b0);
    repeat (17) @(negedge clk);
    nrst = 1'b0;
    #1;
    checks += 3;
    if (txl[0] !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b want 1", txl[0]); end
    if (bsy[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bsy[0]); end
    if (ten[0] !== 1'b0) begin errors++; $display("FAIL midrst_ten got %b want 0", ten[0]); end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    capture(0, 50, -1);
    checks += 3;
    if (cap_dn != 0) begin errors++; $display("FAIL midrst_done_pulses got %0d want 0", cap_dn); end
    if (cap_busy != 0) begin errors++; $display("FAIL midrst_busy_cycles got %0d want 0", cap_busy); end
    if (cap_t !== {128{1'b1}}) begin errors++; $display("FAIL midrst_idle_line got %h want all ones", cap_t); end
    start(0, 8'hC3, 1'b0);
    capture(0, 41, -1);
    e = expand({1'b1, 8'hC3, 1'b0}, 10);
    checks += 2;
    if (cap_t !== e) begin errors++; $display("FAIL midrst_wave got %h want %h", cap_t, e); end
    if (cap_done != 40) begin errors++; $display("FAIL midrst_done_at got %0d want 40", cap_done); end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_stop2;
    test_back_to_back;
    test_busy_ignore;
    test_idle_tick;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
